output_driver: RTL and testbench

Registered output-channel driver with a programmable turn-on delay, minimum on-time, minimum off-time and a maximum-on watchdog. It is the output-side counterpart of the team's input delay filter. It sits between NIOS-II GPIO/PIO command bits and the physical actuator pins. A stuck or chattering command can therefore never produce runt pulses, excessive switching or an unbounded on-time.

---
 rtl/output_driver.sv | 100 ++++++++++
 tb/tb_output_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/output_driver.sv
// Output-channel driver: programmable turn-on delay, minimum on/off times and a
// sticky max-on watchdog between GPIO command bits and actuator pins.
module output_driver #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cmd_in,
    input  logic [CNT_W-1:0] on_delay,
    input  logic [CNT_W-1:0] min_on,
    input  logic [CNT_W-1:0] min_off,
    input  logic [CNT_W-1:0] max_on,
    input  logic             clear_fault,
    output logic             signal_out,
    output logic             fault,
    output logic             active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_ON    = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signal_out_q, signal_out_d;
    logic             fault_q, fault_d;
    logic             active_q, active_d;

    // Next-state selection; conditions are in priority order within each state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable && cmd_in) state_d = S_DELAY;
            end
            S_DELAY: begin
                if (!enable || !cmd_in)   state_d = S_IDLE;
                else if (cnt_q >= on_delay) state_d = S_ON;
            end
            S_ON: begin
                if ((max_on != '0) && (cnt_q >= max_on)) state_d = S_FAULT;
                else if (!enable)                        state_d = S_HOLD;
                else if (!cmd_in && (cnt_q >= min_on))   state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q >= min_off) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clear_fault && !cmd_in) state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Interval counter: clears on any transition, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        signal_out_d = 1'b0;
        fault_d      = 1'b0;
        active_d     = 1'b0;
        signal_out_d = (state_d == S_ON);
        fault_d      = (state_d == S_FAULT);
        active_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            signal_out_q <= 1'b0;
            fault_q      <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            signal_out_q <= signal_out_d;
            fault_q      <= fault_d;
            active_q     <= active_d;
        end
    end

    assign signal_out = signal_out_q;
    assign fault      = fault_q;
    assign active     = active_q;

endmodule

// File: tb/tb_output_driver.sv
// Directed, table-driven bench for output_driver: per-cycle vectors with
// hand-computed outputs plus hand-written chatter and live-reprogram sequences.
module tb_output_driver;

    localparam int unsigned CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst, enable, cmd_in, clear_fault;
    logic [CNT_W-1:0] on_delay, min_on, min_off, max_on;
    logic             signal_out, fault, active;

    int errors = 0;
    int checks = 0;

    output_driver #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd_in      (cmd_in),
        .on_delay    (on_delay),
        .min_on      (min_on),
        .min_off     (min_off),
        .max_on      (max_on),
        .clear_fault (clear_fault),
        .signal_out  (signal_out),
        .fault       (fault),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic             rst, en, cmd, clr;
        logic [CNT_W-1:0] od, mon, moff, mx;
        logic [2:0]       exp;   // {signal_out, fault, active}
    } vec_t;

    vec_t             vecs[$];
    string            cur_tag;
    logic [CNT_W-1:0] p_od, p_mon, p_moff, p_mx;

    function automatic void set_p(input string tag, input int od, input int mon,
                                  input int moff, input int mx);
        cur_tag = tag;
        p_od    = CNT_W'(od);
        p_mon   = CNT_W'(mon);
        p_moff  = CNT_W'(moff);
        p_mx    = CNT_W'(mx);
    endfunction

    // Append n identical cycles with the same expected outputs
    function automatic void add(input int n, input logic r, input logic en, input logic cmd,
                                input logic clr, input logic [2:0] exp);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.tag = cur_tag; v.rst = r; v.en = en; v.cmd = cmd; v.clr = clr;
            v.od = p_od; v.mon = p_mon; v.moff = p_moff; v.mx = p_mx; v.exp = exp;
            vecs.push_back(v);
        end
    endfunction

    task automatic drive(input logic r, input logic en, input logic cmd, input logic clr);
        @(negedge clk);
        rst = r; enable = en; cmd_in = cmd; clear_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] exp);
        checks++;
        if ({signal_out, fault, active} !== exp) begin
            errors++;
            $display("FAIL %s: got sig/flt/act=%b%b%b expected %b", name,
                     signal_out, fault, active, exp);
        end
    endtask

    task automatic chk_cond(input string name, input bit ok, input int actual, input int bound);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required bound %0d", name, actual, bound);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cmd_in = 1'b0; clear_fault = 1'b0;
        on_delay = '0; min_on = '0; min_off = '0; max_on = '0;

        set_p("reset", 0, 0, 0, 0);
        add(2, 1, 0, 0, 0, 3'b000);

        // Turn-on after on_delay+1 edges, off one edge after cmd falls
        set_p("basic", 3, 0, 0, 0);
        add(4, 0, 1, 1, 0, 3'b001);
        add(6, 0, 1, 1, 0, 3'b101);
        add(1, 0, 1, 0, 0, 3'b001);
        add(1, 0, 1, 0, 0, 3'b000);

        set_p("glitch", 5, 0, 0, 0);
        add(4, 0, 1, 1, 0, 3'b001);
        add(2, 0, 1, 0, 0, 3'b000);

        // Minimum on-time stretches a short request to min_on+1 cycles
        set_p("min_on", 0, 8, 0, 0);
        add(1, 0, 1, 1, 0, 3'b001);
        add(1, 0, 1, 1, 0, 3'b101);
        add(8, 0, 1, 0, 0, 3'b101);
        add(1, 0, 1, 0, 0, 3'b001);
        add(1, 0, 1, 0, 0, 3'b000);

        // Watchdog wins over min_on; clear only honoured with cmd low
        set_p("watchdog", 0, 10, 2, 5);
        add(1, 0, 1, 1, 0, 3'b001);
        add(6, 0, 1, 1, 0, 3'b101);
        add(1, 0, 1, 1, 0, 3'b011);
        add(1, 0, 1, 1, 1, 3'b011);
        add(1, 0, 1, 0, 0, 3'b011);
        add(1, 0, 1, 0, 1, 3'b001);
        add(2, 0, 1, 0, 0, 3'b001);
        add(1, 0, 1, 0, 0, 3'b000);

        // Enable-low ignores min_on; reset drops output mid-pulse
        set_p("enable_rst", 0, 100, 1, 0);
        add(1, 0, 1, 1, 0, 3'b001);
        add(3, 0, 1, 1, 0, 3'b101);
        add(1, 0, 0, 1, 0, 3'b001);
        add(1, 0, 0, 1, 0, 3'b001);
        add(1, 0, 0, 1, 0, 3'b000);
        add(1, 0, 1, 1, 0, 3'b001);
        add(2, 0, 1, 1, 0, 3'b101);
        add(1, 1, 1, 1, 0, 3'b000);
        add(2, 0, 1, 0, 0, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            on_delay = vecs[i].od; min_on = vecs[i].mon;
            min_off = vecs[i].moff; max_on = vecs[i].mx;
            drive(vecs[i].rst, vecs[i].en, vecs[i].cmd, vecs[i].clr);
            chk($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].exp);
        end

        // Live reprogram: lowering on_delay below cnt enters ON on the next edge
        on_delay = CNT_W'(50); min_on = '0; min_off = '0; max_on = '0;
        for (int k = 0; k < 11; k++) begin
            drive(0, 1, 1, 0);
            chk($sformatf("reprog_delay[%0d]", k), 3'b001);
        end
        on_delay = CNT_W'(2);
        drive(0, 1, 1, 0);
        chk("reprog_on", 3'b101);
        drive(0, 1, 0, 0);
        chk("reprog_off", 3'b001);
        drive(0, 1, 0, 0);
        chk("reprog_idle", 3'b000);

        // Chatter: rising edges of signal_out must be spaced by min_off+3 or more
        begin
            int  last_rise = -1000;
            int  rises = 0;
            int  min_gap = 1000;
            logic prev = 1'b0;
            on_delay = '0; min_on = '0; min_off = CNT_W'(6); max_on = '0;
            for (int c = 0; c < 90; c++) begin
                drive(0, 1, (c % 3) != 2, 0);
                if (signal_out && !prev) begin
                    if (rises > 0 && (c - last_rise) < min_gap) min_gap = c - last_rise;
                    last_rise = c;
                    rises++;
                end
                prev = signal_out;
            end
            chk_cond("chatter_rises", rises >= 3, rises, 3);
            chk_cond("chatter_spacing", min_gap >= 9, min_gap, 9);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
